mrd_bfp_margin_det: RTL

- Block-floating-point headroom detector placed at the output of each mixed-radix butterfly stage (radix-5 datapath: 5 complex samples per cycle, 18-bit signed).
- Passes data through with a 1-cycle register, tracks the minimum redundant-sign-bit headroom over one frame, then reports it as a 2-bit margin for the next stage's margin input.
- Carries the frame's block exponent alongside the margin.
- Produces the margin/exponent pair that the butterfly consumes; it is the producer side of that interface.

---
 rtl/mrd_bfp_margin_det_if.sv | 33 +++
 rtl/mrd_bfp_margin_det.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mrd_bfp_margin_det_if.sv
// Sample/margin bus between a radix-5 butterfly stage and its headroom detector.
// There is no back-pressure: in_val qualifies a group on the cycle it is high and
// the detector must accept it; out_val and margin_val are likewise one-cycle
// qualifiers with no ready, so every asserted valid is a completed transfer.
interface mrd_bfp_margin_det_if;
  logic              in_val;
  logic              in_sop;
  logic signed [17:0] din_real [0:4];
  logic signed [17:0] din_imag [0:4];
  logic [3:0]        exp_in;
  logic              out_val;
  logic              out_sop;
  logic signed [17:0] dout_real [0:4];
  logic signed [17:0] dout_imag [0:4];
  logic [1:0]        margin_out;
  logic [3:0]        exp_out;
  logic              margin_val;
  logic              frame_err;

  // Upstream side: drives samples, observes the delayed data and the margin.
  modport master (
    output in_val, in_sop, din_real, din_imag, exp_in,
    input  out_val, out_sop, dout_real, dout_imag, margin_out, exp_out,
           margin_val, frame_err
  );

  // Detector side.
  modport slave (
    input  in_val, in_sop, din_real, din_imag, exp_in,
    output out_val, out_sop, dout_real, dout_imag, margin_out, exp_out,
           margin_val, frame_err
  );
endinterface

// File: rtl/mrd_bfp_margin_det.sv
// Block-floating-point headroom detector: registers the 5-sample complex group,
// tracks the minimum redundant-sign-bit headroom over a frame and reports it
// (with the frame's block exponent) two cycles after the frame's last group.
module mrd_bfp_margin_det #(
  parameter int FRAME_LEN = 12,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mrd_bfp_margin_det_if.slave  bus,
  output logic                 o_dbg_state
);
  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  // The counter only ever holds 1..FRAME_LEN-1, so FRAME_LEN = 2^CNT_W still fits.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_exp;
  logic               w_load, w_accum, w_done, w_abort;
  logic [3:0]         w_exp_cur;
  logic [1:0]         w_grp_min;

  logic signed [17:0] r_dout_real [0:4];
  logic signed [17:0] r_dout_imag [0:4];
  logic               r_out_val, r_out_sop;
  logic [1:0]         r_grp_min;
  logic               r_s1_load, r_s1_accum, r_s1_done, r_s1_abort;
  logic [3:0]         r_s1_exp;

  logic [1:0]         r_acc, w_acc_new;
  logic [1:0]         r_margin;
  logic [3:0]         r_exp_out;
  logic               r_margin_val, r_frame_err;

  function automatic logic [1:0] f_headroom(input logic [17:0] x);
    logic [1:0] h;
    if (x[17:14] == 4'b0000 || x[17:14] == 4'b1111)  h = 2'd3;
    else if (x[17:15] == 3'b000 || x[17:15] == 3'b111) h = 2'd2;
    else if (x[17] == x[16])                           h = 2'd1;
    else                                               h = 2'd0;
    return h;
  endfunction

  // Minimum headroom across the ten values of the incoming group.
  always_comb begin
    w_grp_min = 2'd3;
    for (int i = 0; i < 5; i++) begin
      if (f_headroom(bus.din_real[i]) < w_grp_min) w_grp_min = f_headroom(bus.din_real[i]);
      if (f_headroom(bus.din_imag[i]) < w_grp_min) w_grp_min = f_headroom(bus.din_imag[i]);
    end
  end

  // Frame FSM: sop (re)starts a frame, in-frame groups count toward completion.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_accum     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    if (bus.in_val && bus.in_sop) begin
      w_load    = 1'b1;
      w_abort   = (r_state == S_ACC);
      if (FRAME_LEN == 1) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = S_ACC;
        w_cnt_nxt   = CNT_W'(1);
      end
    end else if (bus.in_val && r_state == S_ACC) begin
      w_accum = 1'b1;
      if (r_cnt == LAST_CNT) begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Exponent that belongs to the group now entering: a new sop carries its own.
  assign w_exp_cur = w_load ? bus.exp_in : r_exp;

  // Stage 1: FSM state, data register, group minimum and per-group frame tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_exp       <= '0;
      r_dout_real <= '{default: '0};
      r_dout_imag <= '{default: '0};
      r_out_val   <= 1'b0;
      r_out_sop   <= 1'b0;
      r_grp_min   <= 2'd3;
      r_s1_load   <= 1'b0;
      r_s1_accum  <= 1'b0;
      r_s1_done   <= 1'b0;
      r_s1_abort  <= 1'b0;
      r_s1_exp    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_load) r_exp <= bus.exp_in;
      r_out_val  <= bus.in_val;
      r_out_sop  <= bus.in_sop;
      if (bus.in_val) begin
        r_dout_real <= bus.din_real;
        r_dout_imag <= bus.din_imag;
        r_grp_min   <= w_grp_min;
      end
      r_s1_load  <= w_load;
      r_s1_accum <= w_accum;
      r_s1_done  <= w_done;
      r_s1_abort <= w_abort;
      r_s1_exp   <= w_exp_cur;
    end
  end

  // A sop group replaces the running minimum instead of merging with it.
  assign w_acc_new = r_s1_load ? r_grp_min :
                     ((r_grp_min < r_acc) ? r_grp_min : r_acc);

  // Stage 2: frame accumulator and the margin/error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= 2'd3;
      r_margin     <= '0;
      r_exp_out    <= '0;
      r_margin_val <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (r_s1_load || r_s1_accum) r_acc <= w_acc_new;
      r_margin_val <= r_s1_done;
      r_frame_err  <= r_s1_abort;
      if (r_s1_done) begin
        r_margin  <= w_acc_new;
        r_exp_out <= r_s1_exp;
      end
    end
  end

  assign bus.dout_real  = r_dout_real;
  assign bus.dout_imag  = r_dout_imag;
  assign bus.out_val    = r_out_val;
  assign bus.out_sop    = r_out_sop;
  assign bus.margin_out = r_margin;
  assign bus.exp_out    = r_exp_out;
  assign bus.margin_val = r_margin_val;
  assign bus.frame_err  = r_frame_err;
  assign o_dbg_state    = r_state;
endmodule
